// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: latches decoded operands and write-back control
// for EX, with bubble insertion, hold, Tnew countdown and a bubble counter.
module id_ex_reg #(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_3000,
   parameter int               CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             clr,
   input  logic [WIDTH-1:0] Instr_D,
   input  logic [WIDTH-1:0] PC8_D,
   input  logic [WIDTH-1:0] RD1_D,
   input  logic [WIDTH-1:0] RD2_D,
   input  logic [WIDTH-1:0] Imm32_D,
   input  logic [4:0]       A3_D,
   input  logic             RegWrite_D,
   input  logic [1:0]       Tnew_D,
   output logic [WIDTH-1:0] Instr_E,
   output logic [WIDTH-1:0] PC8_E,
   output logic [WIDTH-1:0] RD1_E,
   output logic [WIDTH-1:0] RD2_E,
   output logic [WIDTH-1:0] Imm32_E,
   output logic [4:0]       A3_E,
   output logic             RegWrite_E,
   output logic [1:0]       Tnew_E,
   output logic             Valid_E,
   output logic [CNT_W-1:0] BubbleCnt
);

   localparam logic [WIDTH-1:0] PC8_RST = RESET_PC + WIDTH'(8);

   logic       regwrite_nxt;
   logic [1:0] tnew_nxt;

   // $0 is never a real destination; hiding it keeps forwarding quiet
   assign regwrite_nxt = RegWrite_D & (|A3_D);
   assign tnew_nxt     = (Tnew_D == 2'd0) ? 2'd0 : Tnew_D - 2'd1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         Instr_E    <= '0;
         PC8_E      <= PC8_RST;
         RD1_E      <= '0;
         RD2_E      <= '0;
         Imm32_E    <= '0;
         A3_E       <= '0;
         RegWrite_E <= 1'b0;
         Tnew_E     <= 2'd0;
         Valid_E    <= 1'b0;
         BubbleCnt  <= '0;
      end else if (clr) begin
         // bubble is sll $0,$0,0; PC kept for trace
         Instr_E    <= '0;
         PC8_E      <= PC8_D;
         RD1_E      <= '0;
         RD2_E      <= '0;
         Imm32_E    <= '0;
         A3_E       <= '0;
         RegWrite_E <= 1'b0;
         Tnew_E     <= 2'd0;
         Valid_E    <= 1'b0;
         BubbleCnt  <= BubbleCnt + CNT_W'(1);
      end else if (en) begin
         Instr_E    <= Instr_D;
         PC8_E      <= PC8_D;
         RD1_E      <= RD1_D;
         RD2_E      <= RD2_D;
         Imm32_E    <= Imm32_D;
         A3_E       <= A3_D;
         RegWrite_E <= regwrite_nxt;
         Tnew_E     <= tnew_nxt;
         Valid_E    <= 1'b1;
      end
   end

endmodule

// File: tb/tb_id_ex_reg.sv
// Bench for id_ex_reg: vector table, directed corner sequences and
// randomized traffic against a behavioural model.
module tb_id_ex_reg;

   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          reset, en, clr;
   logic [31:0]   Instr_D, PC8_D, RD1_D, RD2_D, Imm32_D;
   logic [4:0]    A3_D;
   logic          RegWrite_D;
   logic [1:0]    Tnew_D;
   logic [31:0]   Instr_E, PC8_E, RD1_E, RD2_E, Imm32_E;
   logic [4:0]    A3_E;
   logic          RegWrite_E;
   logic [1:0]    Tnew_E;
   logic          Valid_E;
   logic [CW-1:0] BubbleCnt;

   int n_chk = 0;
   int n_fail = 0;

   id_ex_reg #(.WIDTH(32), .RESET_PC(32'h0000_3000), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .en(en), .clr(clr),
      .Instr_D(Instr_D), .PC8_D(PC8_D), .RD1_D(RD1_D), .RD2_D(RD2_D),
      .Imm32_D(Imm32_D), .A3_D(A3_D), .RegWrite_D(RegWrite_D),
      .Tnew_D(Tnew_D),
      .Instr_E(Instr_E), .PC8_E(PC8_E), .RD1_E(RD1_E), .RD2_E(RD2_E),
      .Imm32_E(Imm32_E), .A3_E(A3_E), .RegWrite_E(RegWrite_E),
      .Tnew_E(Tnew_E), .Valid_E(Valid_E), .BubbleCnt(BubbleCnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        en, clr;
      logic [31:0] instr, pc8, rd1, rd2, imm;
      logic [4:0]  a3;
      logic        rw;
      logic [1:0]  tnew;
      logic [31:0] e_instr, e_pc8, e_rd1, e_rd2, e_imm;
      logic [4:0]  e_a3;
      logic        e_rw;
      logic [1:0]  e_tnew;
      logic        e_valid;
      int          e_bcnt;
   } vec_t;

   typedef struct {
      logic [31:0] instr, pc8, rd1, rd2, imm;
      logic [4:0]  a3;
      logic        rw;
      int          tnew;
      logic        valid;
      int          bcnt;
   } st_t;

   vec_t vt[7];
   st_t  m;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic e, input logic c, input logic [31:0] i,
                        input logic [31:0] p, input logic [31:0] r1,
                        input logic [31:0] r2, input logic [31:0] im,
                        input logic [4:0] a, input logic w,
                        input logic [1:0] t);
      en = e; clr = c; Instr_D = i; PC8_D = p; RD1_D = r1; RD2_D = r2;
      Imm32_D = im; A3_D = a; RegWrite_D = w; Tnew_D = t;
   endtask

   // Expected EX state after one edge, from the stated rules
   function automatic void model_edge();
      if (clr) begin
         m.instr = 0; m.rd1 = 0; m.rd2 = 0; m.imm = 0; m.a3 = 0;
         m.rw = 0; m.tnew = 0; m.valid = 0; m.pc8 = PC8_D;
         m.bcnt = (m.bcnt + 1) % (1 << CW);
      end else if (en) begin
         m.instr = Instr_D; m.pc8 = PC8_D; m.rd1 = RD1_D; m.rd2 = RD2_D;
         m.imm = Imm32_D; m.a3 = A3_D; m.valid = 1;
         m.rw = RegWrite_D && (A3_D != 5'd0);
         m.tnew = (int'(Tnew_D) > 0) ? int'(Tnew_D) - 1 : 0;
      end
   endfunction

   function automatic void model_reset();
      m.instr = 0; m.rd1 = 0; m.rd2 = 0; m.imm = 0; m.a3 = 0; m.rw = 0;
      m.tnew = 0; m.valid = 0; m.bcnt = 0; m.pc8 = 32'h0000_3008;
   endfunction

   task automatic chk_model(input string tag);
      chk({tag, ".instr"}, Instr_E, m.instr);
      chk({tag, ".pc8"}, PC8_E, m.pc8);
      chk({tag, ".rd1"}, RD1_E, m.rd1);
      chk({tag, ".rd2"}, RD2_E, m.rd2);
      chk({tag, ".imm"}, Imm32_E, m.imm);
      chk({tag, ".a3"}, 32'(A3_E), 32'(m.a3));
      chk({tag, ".rw"}, 32'(RegWrite_E), 32'(m.rw));
      chk({tag, ".tnew"}, 32'(Tnew_E), 32'(m.tnew));
      chk({tag, ".valid"}, 32'(Valid_E), 32'(m.valid));
      chk({tag, ".bcnt"}, 32'(BubbleCnt), 32'(m.bcnt));
   endtask

   function automatic vec_t mk(logic e, logic c, logic [31:0] i,
                               logic [31:0] p, logic [31:0] r1,
                               logic [31:0] r2, logic [31:0] im,
                               logic [4:0] a, logic w, logic [1:0] t,
                               logic [31:0] ei, logic [31:0] ep,
                               logic [31:0] er1, logic [31:0] er2,
                               logic [31:0] eim, logic [4:0] ea,
                               logic ew, logic [1:0] et, logic ev,
                               int eb);
      vec_t v;
      v.en = e; v.clr = c; v.instr = i; v.pc8 = p; v.rd1 = r1; v.rd2 = r2;
      v.imm = im; v.a3 = a; v.rw = w; v.tnew = t;
      v.e_instr = ei; v.e_pc8 = ep; v.e_rd1 = er1; v.e_rd2 = er2;
      v.e_imm = eim; v.e_a3 = ea; v.e_rw = ew; v.e_tnew = et;
      v.e_valid = ev; v.e_bcnt = eb;
      return v;
   endfunction

   initial begin
      vt[0] = mk(1, 0, 32'h3C01_1234, 32'h3010, 32'h0, 32'h0, 32'h1234_0000,
                 1, 1, 2,
                 32'h3C01_1234, 32'h3010, 32'h0, 32'h0, 32'h1234_0000,
                 1, 1, 1, 1, 0);
      vt[1] = mk(1, 0, 32'h0000_1020, 32'h3014, 32'h1111_1111, 32'h7,
                 32'h0, 0, 1, 1,
                 32'h0000_1020, 32'h3014, 32'h1111_1111, 32'h7, 32'h0,
                 0, 0, 0, 1, 0);
      vt[2] = mk(1, 1, 32'h3C02_FFFF, 32'h3010, 32'h22, 32'h33,
                 32'hFFFF_0000, 2, 1, 2,
                 32'h0, 32'h3010, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 1);
      vt[3] = mk(0, 0, 32'hAAAA_AAAA, 32'h5555, 32'h44, 32'h55, 32'h66,
                 9, 1, 3,
                 32'h0, 32'h3010, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 1);
      vt[4] = mk(1, 0, 32'h8C03_0004, 32'h3018, 32'hDEAD_BEEF, 32'h1,
                 32'h4, 3, 1, 0,
                 32'h8C03_0004, 32'h3018, 32'hDEAD_BEEF, 32'h1, 32'h4,
                 3, 1, 0, 1, 1);
      vt[5] = mk(1, 0, 32'h0100_0008, 32'h301C, 32'h5, 32'h6, 32'h8,
                 31, 0, 3,
                 32'h0100_0008, 32'h301C, 32'h5, 32'h6, 32'h8,
                 31, 0, 2, 1, 1);
      vt[6] = mk(0, 1, 32'h2001_0001, 32'h3020, 32'h9, 32'h9, 32'h1,
                 1, 1, 1,
                 32'h0, 32'h3020, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 2);

      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      reset = 1'b1;
      step();
      step();

      // async reset mid-cycle after a capture
      reset = 1'b0;
      drive(1, 0, 32'h1234_5678, 32'h4000, 32'h1, 32'h2, 32'h3, 4, 1, 2);
      step();
      chk("precap.instr", Instr_E, 32'h1234_5678);
      #2 reset = 1'b1;
      #1;
      chk("arst.instr", Instr_E, 32'h0);
      chk("arst.pc8", PC8_E, 32'h0000_3008);
      chk("arst.valid", 32'(Valid_E), 32'h0);
      chk("arst.rw", 32'(RegWrite_E), 32'h0);
      chk("arst.bcnt", 32'(BubbleCnt), 32'h0);
      step();
      reset = 1'b0;

      foreach (vt[k]) begin
         drive(vt[k].en, vt[k].clr, vt[k].instr, vt[k].pc8, vt[k].rd1,
               vt[k].rd2, vt[k].imm, vt[k].a3, vt[k].rw, vt[k].tnew);
         step();
         chk($sformatf("v%0d.instr", k), Instr_E, vt[k].e_instr);
         chk($sformatf("v%0d.pc8", k), PC8_E, vt[k].e_pc8);
         chk($sformatf("v%0d.rd1", k), RD1_E, vt[k].e_rd1);
         chk($sformatf("v%0d.rd2", k), RD2_E, vt[k].e_rd2);
         chk($sformatf("v%0d.imm", k), Imm32_E, vt[k].e_imm);
         chk($sformatf("v%0d.a3", k), 32'(A3_E), 32'(vt[k].e_a3));
         chk($sformatf("v%0d.rw", k), 32'(RegWrite_E), 32'(vt[k].e_rw));
         chk($sformatf("v%0d.tnew", k), 32'(Tnew_E), 32'(vt[k].e_tnew));
         chk($sformatf("v%0d.valid", k), 32'(Valid_E), 32'(vt[k].e_valid));
         chk($sformatf("v%0d.bcnt", k), 32'(BubbleCnt), 32'(vt[k].e_bcnt));
      end

      // hold for 3 cycles with changing D-side
      drive(1, 0, 32'h0022_0820, 32'h3030, 32'hDEAD_BEEF, 32'h0, 32'h0,
            1, 1, 2);
      step();
      for (int i = 0; i < 3; i++) begin
         en = 1'b0;
         RD1_D = $urandom;
         Tnew_D = 2'(i);
         step();
         chk($sformatf("hold%0d.rd1", i), RD1_E, 32'hDEAD_BEEF);
         chk($sformatf("hold%0d.tnew", i), 32'(Tnew_E), 32'h1);
         chk($sformatf("hold%0d.bcnt", i), 32'(BubbleCnt), 32'h2);
      end

      // bubble with unknown data must still be a clean NOP
      drive(1, 1, 'x, 32'h3040, 'x, 'x, 'x, 'x, 'x, 'x);
      step();
      chk("xbub.instr", Instr_E, 32'h0);
      chk("xbub.a3", 32'(A3_E), 32'h0);
      chk("xbub.rw", 32'(RegWrite_E), 32'h0);
      chk("xbub.tnew", 32'(Tnew_E), 32'h0);
      chk("xbub.pc8", PC8_E, 32'h3040);

      // counter wrap: 17 bubbles from reset lands on 1
      reset = 1'b1;
      #1;
      chk("wrst.bcnt", 32'(BubbleCnt), 32'h0);
      step();
      reset = 1'b0;
      drive(0, 1, 0, 32'h3000, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 17; i++) step();
      chk("wrap.bcnt", 32'(BubbleCnt), 32'h1);
      #2 reset = 1'b1;
      #1;
      chk("wrap.arst.bcnt", 32'(BubbleCnt), 32'h0);
      step();
      reset = 1'b0;
      model_reset();

      // randomized traffic against the model
      for (int i = 0; i < 300; i++) begin
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
               $urandom, $urandom, $urandom, $urandom, $urandom,
               5'($urandom_range(0, 3) == 0 ? 0 : $urandom),
               1'($urandom), 2'($urandom));
         model_edge();
         step();
         chk_model($sformatf("rnd%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/id_ex_reg.md
Name: id_ex_reg

Overview:
ID/EX pipeline register. It sits directly downstream of the ID-stage immediate extender and register-file read. It latches the extended immediate, the operands, the instruction word, PC+8 and the write-back control so the EX stage can use them. It also supports stall-bubble insertion, hold for multi-cycle EX stalls, Tnew countdown for the hazard unit, and a bubble performance counter.

Parameters:
WIDTH, 32, datapath width for operands, immediate, PC and instruction
RESET_PC, 32'h0000_3000, PC of the first instruction; PC8_E resets to RESET_PC+8
CNT_W, 16, width of the bubble performance counter

Ports:
clk  in  1  pipeline clock, rising edge
reset  in  1  asynchronous, active-high reset
en  in  1  1 = capture D-side values; 0 = hold current contents
clr  in  1  1 = load a bubble (NOP) next edge; overrides en
Instr_D  in  WIDTH  instruction word in ID
PC8_D  in  WIDTH  PC+8 of the ID instruction
RD1_D  in  WIDTH  forwarded rs value
RD2_D  in  WIDTH  forwarded rt value
Imm32_D  in  WIDTH  extender output
A3_D  in  5  destination register number
RegWrite_D  in  1  instruction writes the GPR file
Tnew_D  in  2  cycles until the result is produced, counted from ID
Instr_E  out  WIDTH  registered instruction
PC8_E  out  WIDTH  registered PC+8
RD1_E  out  WIDTH  registered rs value
RD2_E  out  WIDTH  registered rt value
Imm32_E  out  WIDTH  registered immediate
A3_E  out  5  registered destination
RegWrite_E  out  1  registered write enable, qualified by A3
Tnew_E  out  2  Tnew as seen in EX
Valid_E  out  1  1 = real instruction; 0 = bubble
BubbleCnt  out  CNT_W  number of bubble cycles inserted since reset

Behaviour:
- Reset is asynchronous and active-high. It takes effect immediately, independent of clk.
- Values while reset is asserted:
  - Instr_E, RD1_E, RD2_E, Imm32_E, A3_E, RegWrite_E, Tnew_E, Valid_E, BubbleCnt all 0.
  - PC8_E = RESET_PC+8.
- Release is synchronous to the next rising edge. The first capture uses that edge.
- Priority on each rising edge: reset > clr > en > hold.
- Capture (en=1, clr=0):
  - All D fields copied to E. Valid_E <= 1.
  - RegWrite_E <= RegWrite_D & (A3_D != 0). Writes to $0 are never advertised to forwarding.
  - Tnew_E <= (Tnew_D == 0) ? 0 : Tnew_D - 1. Saturating, never wraps to 3.
- Bubble (clr=1, any en):
  - Instr_E, RD1_E, RD2_E, Imm32_E, A3_E, RegWrite_E, Tnew_E, Valid_E <= 0.
  - PC8_E <= PC8_D. The PC is kept for debug/trace.
  - BubbleCnt <= BubbleCnt + 1.
- Hold (en=0, clr=0): every output, including BubbleCnt, keeps its value. Tnew_E does not count down while held.
- BubbleCnt wraps modulo 2^CNT_W: all-ones + 1 = 0. No saturation, no sticky flag.
- Latency: exactly one edge from D inputs to E outputs. No combinational path from any input to any output.
- A bubble (Instr 0 = sll $0,$0,0) must look to EX/MEM/WB exactly like a NOP: RegWrite_E=0, A3_E=0.
- Simultaneous clr and en: clr wins. This is the normal load-use stall case, where the hazard unit drives both.
- Reset asserted mid-stall or mid-hold: outputs go to reset values immediately. BubbleCnt clears.
- All registers are updated in one clocked process, with a separate asynchronous reset branch. No latches. X on inputs must not propagate while clr=1.

Test Plan:
1. Reset: assert reset mid-cycle -> outputs immediately 0, PC8_E=32'h0000_3008. Release, then en=1, Instr_D=32'h3C01_1234, Imm32_D=32'h1234_0000, A3_D=1, RegWrite_D=1, Tnew_D=2 -> after one edge: Instr_E=32'h3C01_1234, Imm32_E=32'h1234_0000, RegWrite_E=1, Tnew_E=1, Valid_E=1.
2. $0 suppression: capture with A3_D=0, RegWrite_D=1 -> RegWrite_E=0, A3_E=0, Valid_E=1.
3. Bubble priority: clr=1, en=1, PC8_D=32'h0000_3010, with valid D data -> Instr_E=0, RegWrite_E=0, Valid_E=0, PC8_E=32'h0000_3010, BubbleCnt increments by 1.
4. Hold: capture RD1_D=32'hDEAD_BEEF, then en=0 for 3 cycles while RD1_D changes -> RD1_E stays 32'hDEAD_BEEF and Tnew_E stays constant.
5. Tnew saturation: Tnew_D=0 -> Tnew_E=0. Tnew_D=3 -> Tnew_E=2.
6. Counter wrap: CNT_W=4, apply 17 consecutive clr cycles -> BubbleCnt reads 1. Then assert reset -> BubbleCnt=0 asynchronously.
